add_seq16: RTL and testbench

ADD_SEQ16 -- requirements
Module: add_seq16

---
 rtl/add_seq16.sv | 133 +++++++++++++
 tb/tb_add_seq16.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq16.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice walks the
// operands LSB nibble first, then holds the result until it is consumed.
module add_seq16 #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [3:0]      nib_a, nib_b, g, p, slice_sum;
    logic [4:0]      c;
    int unsigned     base;

    // Nibble selected by the running index feeds the lookahead slice.
    always_comb begin
        base  = 4 * int'(idx_q);
        nib_a = opa_q[base +: 4];
        nib_b = opb_q[base +: 4];
    end

    assign g    = nib_a & nib_b;
    assign p    = nib_a | nib_b;
    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sum
        assign slice_sum[gi] = nib_a[gi] ^ nib_b[gi] ^ c[gi];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so the sub flag is fully
                    // absorbed into opB and the initial carry here.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: 4] = slice_sum;
                carry_d          = c[4];
                idx_d            = idx_q + IW'(1);
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = c[4];
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (slice_sum[3] != opa_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq16.sv
// Self-checking bench for add_seq16: directed table, handshake corner cases,
// and a randomized stream scored against an arithmetic reference model.
module tb_add_seq16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout, ovf;

    int vecs = 0;
    int errs = 0;

    logic [17:0] exp_q[$];

    add_seq16 #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain unsigned/signed integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        int unsigned ua, ub, full;
        int          sa, sb, sres;
        logic        mc, mo;
        ua = ma;
        ub = mb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (!msub) begin
            full = ua + ub + mcin;
            mc   = (full > 65535);
            sres = sa + sb + int'(mcin);
        end else begin
            full = (ua - ub) & 32'hFFFF;
            mc   = (ua >= ub);
            sres = sa - sb;
        end
        mo = (sres > 32767) || (sres < -32768);
        return {mo, mc, full[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                          input logic tsub, output logic [15:0] rs, output logic rc,
                          output logic ro, output int lat);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout; ro = ovf;
        $display("op a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d ovf=%0d lat=%0d",
                 ta, tb_v, tcin, tsub, rs, rc, ro, lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] r_sum, hold_sum;
    logic        r_cout, r_ovf, hold_cout, hold_ovf;
    int          lat, pulses;

    initial begin
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

        // Reset with in_valid held high: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("rst_no_accept", 32'(pulses), 32'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, r_sum, r_cout, r_ovf, lat);
            check($sformatf("tbl%0d_sum", i), 32'(r_sum), 32'(tbl[i].e_sum));
            check($sformatf("tbl%0d_cout", i), 32'(r_cout), 32'(tbl[i].e_cout));
            check($sformatf("tbl%0d_ovf", i), 32'(r_ovf), 32'(tbl[i].e_ovf));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
            consume();
        end

        // Backpressure: three stalled cycles in DONE with a competing in_valid.
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, hold_sum, hold_cout, hold_ovf, lat);
        a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_sum_stable", 32'({hold_ovf, hold_cout, hold_sum}), 32'({ovf, cout, sum}));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        check("bp_result", 32'({hold_ovf, hold_cout, hold_sum}), 32'({1'b1, 1'b0, 16'h8000}));
        in_valid = 1'b0;
        consume();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("bp_no_hidden_accept", 32'(pulses), 32'd0);

        // Reset while RUN is at nibble index 2.
        a = 16'h0F0F; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout_ovf", 32'({cout, ovf}), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("abort_no_result", 32'(pulses), 32'd0);

        // Randomized stream with gaps on both sides.
        fork
            begin : driver
                for (int i = 0; i < 100; i++) begin
                    int waitc;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    a = 16'($urandom); b = 16'($urandom);
                    cin = 1'($urandom); sub = 1'($urandom);
                    if (i % 10 == 0) a = 16'h8000;
                    if (i % 10 == 5) b = 16'hFFFF;
                    in_valid = 1'b1;
                    waitc = 0;
                    while (!in_ready && waitc < 60) begin
                        @(posedge clk); #1;
                        waitc++;
                    end
                    if (waitc >= 60) begin
                        check("stream_accept_timeout", 32'(waitc), 32'd0);
                        in_valid = 1'b0;
                        break;
                    end
                    exp_q.push_back(model(a, b, cin, sub));
                    $display("stream in #%0d a=%04h b=%04h cin=%0d sub=%0d", i, a, b, cin, sub);
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
            end
            begin : monitor
                int got, cyc;
                logic [17:0] e;
                got = 0;
                cyc = 0;
                while (got < 100 && cyc < 20000) begin
                    @(posedge clk); #1;
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("stream_unexpected_result", 32'(got), 32'(-1));
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("stream%0d", got), 32'({ovf, cout, sum}), 32'(e));
                            $display("stream out #%0d sum=%04h cout=%0d ovf=%0d", got, sum, cout, ovf);
                        end
                        got++;
                    end
                end
                out_ready = 1'b0;
                check("stream_count", 32'(got), 32'd100);
            end
        join
        check("stream_leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
